// File: rtl/spi_master_param.sv
// Parameterised SPI master with a small register interface: CPOL/CPHA/bit-order
// control, programmable sclk divider, up to 8 active-low slave selects.
module spi_master_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSS    = 4,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic              sclk,
  output logic [NSS-1:0]    ss,
  output logic              mosi,
  input  logic              miso,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0] address,
  input  logic              sel,
  input  logic              read,
  input  logic              write,
  output logic              interrupt
);

  localparam int unsigned EW = $clog2(2 * DATA_W) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CLKDIV = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TX     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RX     = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_INT_EN = ADDR_W'(5);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t            state;
  logic [5:0]        ctrl;
  logic [DIV_W-1:0]  clkdiv;
  logic [DIV_W-1:0]  cnt;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] shreg;
  logic [EW-1:0]     edges;
  logic              ready;
  logic              int_en;
  logic              f_cpha;
  logic              f_lsb;
  logic              samp;

  logic busy, wr, rd, tx_start, rx_read;

  assign wr        = sel & write;
  assign rd        = sel & read;
  assign busy      = (state != IDLE);
  assign tx_start  = wr && (address == A_TX) && !busy;
  assign rx_read   = rd && (address == A_RX);
  assign interrupt = int_en & ready;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sr,
                                                 input logic b, input logic lsb);
    return lsb ? {b, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], b};
  endfunction

  function automatic logic out_bit(input logic [DATA_W-1:0] sr, input logic lsb);
    return lsb ? sr[0] : sr[DATA_W-1];
  endfunction

  // An index beyond the populated lines leaves every select high.
  function automatic logic [NSS-1:0] ss_decode(input logic [2:0] idx);
    logic [NSS-1:0] v;
    v = '1;
    for (int unsigned i = 0; i < NSS; i++)
      if (32'(idx) == i) v[i] = 1'b0;
    return v;
  endfunction

  always_comb begin
    data_out = '0;
    if (address == A_CTRL)        data_out = DATA_W'(ctrl);
    else if (address == A_CLKDIV) data_out = DATA_W'(clkdiv);
    else if (address == A_RX)     data_out = rx;
    else if (address == A_STATUS) data_out = DATA_W'({busy, ready});
    else if (address == A_INT_EN) data_out = DATA_W'(int_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ctrl   <= '0;
      clkdiv <= '0;
      cnt    <= '0;
      rx     <= '0;
      shreg  <= '0;
      edges  <= '0;
      ready  <= 1'b0;
      int_en <= 1'b0;
      f_cpha <= 1'b0;
      f_lsb  <= 1'b0;
      samp   <= 1'b0;
      sclk   <= 1'b0;
      ss     <= '1;
      mosi   <= 1'b0;
    end else begin
      if (wr && address == A_INT_EN)         int_en <= data_in[0];
      if (wr && address == A_CTRL && !busy)   ctrl   <= data_in[5:0];
      if (wr && address == A_CLKDIV && !busy) clkdiv <= data_in[DIV_W-1:0];
      if (rx_read) ready <= 1'b0;

      case (state)
        IDLE: begin
          sclk <= ctrl[0];
          if (tx_start) begin
            shreg  <= data_in;
            f_cpha <= ctrl[1];
            f_lsb  <= ctrl[2];
            ready  <= 1'b0;
            ss     <= ss_decode(ctrl[5:3]);
            mosi   <= out_bit(data_in, ctrl[2]);
            cnt    <= clkdiv;
            edges  <= '0;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= clkdiv;
            state <= XFER;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        XFER: begin
          if (cnt == '0) begin
            cnt   <= clkdiv;
            sclk  <= ~sclk;
            edges <= edges + 1'b1;
            // Even edge count = leading edge, odd = trailing edge.
            if (!edges[0]) begin
              if (!f_cpha) begin
                samp <= miso;
              end else begin
                mosi  <= out_bit(shreg, f_lsb);
                shreg <= shift_in(shreg, 1'b0, f_lsb);
              end
            end else begin
              if (!f_cpha) begin
                shreg <= shift_in(shreg, samp, f_lsb);
                mosi  <= out_bit(shift_in(shreg, samp, f_lsb), f_lsb);
              end else if (f_lsb) begin
                shreg[DATA_W-1] <= miso;
              end else begin
                shreg[0] <= miso;
              end
            end
            if (edges == LAST_EDGE) state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            ss    <= '1;
            rx    <= shreg;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, frame and register width (8..32).
REQ-002 SHALL have parameter NSS, default 4, number of slave-select lines (1..8).
REQ-003 SHALL have parameter DIV_W, default 8, width of the clock-divider register.
REQ-004 SHALL have parameter ADDR_W, default 3, control address width.
REQ-005 clk  input  1  system clock; the only clock, and all logic SHALL be on posedge clk.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 sclk  output  1  SPI clock, generated internally.
REQ-008 ss  output  NSS  active-low slave selects.
REQ-009 mosi  output  1  serial data out.
REQ-010 miso  input  1  serial data in, already synchronous to clk.
REQ-011 data_in  input  DATA_W  write data.
REQ-012 data_out  output  DATA_W  combinational read data.
REQ-013 address  input  ADDR_W  register select.
REQ-014 sel, read, write  input  1 each  access strobes; an access occurs on the cycle where sel&write or sel&read is high.
REQ-015 interrupt  output  1  level equal to int_en & ready.

Function
REQ-016 Register map:
- 0 CTRL (RW): bit0 CPOL, bit1 CPHA, bit2 LSB_FIRST, bits[5:3] SS_IDX.
- 1 CLKDIV (RW, DIV_W bits).
- 2 TX (W): loads the shift register and starts a frame.
- 3 RX (R): returns the received word; the read clears ready.
- 4 STATUS (R): bit0 ready, bit1 busy.
- 5 INT_EN (RW, bit0).
- Other addresses SHALL read 0 and ignore writes.
REQ-017 A half-period of sclk SHALL last CLKDIV+1 clk cycles, counted by a DIV_W-bit down-counter.
REQ-018 FSM states SHALL be IDLE, SETUP, XFER, HOLD; busy=1 in any state other than IDLE.
REQ-019 IDLE->SETUP on a TX write:
- the TX word loads the shift register;
- CTRL is latched for the frame;
- ready clears;
- ss[SS_IDX] goes low on the next cycle.
REQ-020 SETUP SHALL last one half-period, then go to XFER.
REQ-021 XFER SHALL produce exactly 2*DATA_W sclk edges, one per half-period, and then go to HOLD.
REQ-022 sclk SHALL idle at CPOL; the leading edge is the first edge after SETUP.
REQ-023 CPHA=0: mosi SHALL be valid from ss fall; miso is sampled on leading edges; mosi shifts on trailing edges.
REQ-024 CPHA=1: mosi shifts on leading edges; miso is sampled on trailing edges.
REQ-025 LSB_FIRST=1 SHALL shift out bit0 first and shift received bits in from the MSB; LSB_FIRST=0 mirrors this (MSB out first, received bits enter at bit0).
REQ-026 HOLD SHALL last one half-period, then:
- all ss go high;
- RX is updated with the received word;
- ready sets;
- the FSM returns to IDLE.
REQ-027 TX, CTRL and CLKDIV writes while busy SHALL be ignored.
REQ-028 When SS_IDX >= NSS, no ss line SHALL assert, but the frame SHALL still run.
REQ-029 A RX read on the same cycle that ready sets SHALL leave ready=1.
REQ-030 A TX write on the same cycle as an RX read in IDLE SHALL start the frame and clear ready.
REQ-031 CLKDIV=0 SHALL give sclk = clk/2 during XFER.

Reset
REQ-032 On rst all registers SHALL clear immediately, including mid-frame:
- FSM to IDLE;
- CTRL=0, CLKDIV=0, RX=0, ready=0, int_en=0, shift register=0;
- sclk=0, ss=all ones, mosi=0, interrupt=0.
REQ-033 After rst deasserts, the block SHALL accept a TX write on the first clk edge.

Verification
REQ-034 Mode 0, CLKDIV=1, SS_IDX=0, TX=0xA5A5_0F0F, miso looped to mosi -> 32 sclk periods of 4 clk each, ss[0] low only for the frame, RX=0xA5A5_0F0F, STATUS=1.
REQ-035 Mode 3 (CPOL=1, CPHA=1), LSB_FIRST=0, miso tied 1 -> sclk idles high, MSB appears first on mosi, RX=0xFFFF_FFFF.
REQ-036 INT_EN=1 then a frame -> interrupt rises with ready; RX read -> interrupt=0 on the next cycle.
REQ-037 A second TX write (0x1234_5678) mid-frame -> ignored; the frame completes with the original data; busy stays 1 until HOLD ends.
REQ-038 rst asserted in the middle of XFER -> same cycle: ss=all ones, sclk=0, STATUS=0; then a new frame completes correctly.
REQ-039 SS_IDX=7 with NSS=4 -> no ss asserts; ready still sets after 2*DATA_W edges.
